// File: rtl/rv_id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: datapath width, operand-select
// encodings, forward-select encodings and the ID/EX register layout.
`ifndef XLEN
`define XLEN 32
`endif

package rv_id_ex_stage_pkg;

  localparam int XLEN = `XLEN;

  localparam logic SRC_A_SEL_RS1 = 1'b0;
  localparam logic SRC_A_SEL_PC  = 1'b1;
  localparam logic SRC_B_SEL_RS2 = 1'b0;
  localparam logic SRC_B_SEL_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [1:0] {
    FWD_SEL_RF  = 2'd0,
    FWD_SEL_MEM = 2'd1,
    FWD_SEL_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            src_a_sel;
    logic            src_b_sel;
    logic [3:0]      alu_ctrl;
    logic [4:0]      rd_addr;
    logic            reg_wr;
    logic            mem_rd;
    logic            mem_wr;
  } id_ex_t;

  // True when a used ID source names rd; x0 never creates a dependency.
  function automatic logic reads_reg(input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic rs1_used,
                                     input logic [4:0] rs2, input logic rs2_used);
    return (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/rv_id_ex_stage_hazard.sv
// rv_hazard_unit: combinational stall and per-source forward selection.
// RV_EX_FORWARDING_EN enables the MEM bypass; without it MEM/EX producers stall.
import rv_id_ex_stage_pkg::*;

module rv_hazard_unit (
  input  logic     id_valid,
  input  logic     flush,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic     id_rs1_used,
  input  logic     id_rs2_used,
  input  logic     ex_valid,
  input  logic     ex_mem_rd,
`ifndef RV_EX_FORWARDING_EN
  input  logic     ex_reg_wr,
`endif
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] ex_rs1_addr,
  input  logic [4:0] ex_rs2_addr,
  input  logic [4:0] mem_rd_addr,
  input  logic     mem_reg_wr,
  input  logic [4:0] wb_rd_addr,
  input  logic     wb_reg_wr,
  output logic     stall,
  output fwd_sel_e fwd_a_sel,
  output fwd_sel_e fwd_b_sel
);

  logic ld_use;
  logic dep_stall;

  assign ld_use = ex_valid && ex_mem_rd &&
                  reads_reg(ex_rd_addr, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used);

`ifdef RV_EX_FORWARDING_EN
  assign dep_stall = 1'b0;
`else
  assign dep_stall =
    (ex_valid && ex_reg_wr &&
     reads_reg(ex_rd_addr, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used)) ||
    (mem_reg_wr &&
     reads_reg(mem_rd_addr, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used));
`endif

  // A flush squashes the ID instruction, so it never needs to wait.
  assign stall = id_valid && !flush && (ld_use || dep_stall);

  // Later assignments win: MEM is younger than WB and takes priority.
  always_comb begin
    fwd_a_sel = FWD_SEL_RF;
    fwd_b_sel = FWD_SEL_RF;
    if (wb_reg_wr && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs1_addr)) fwd_a_sel = FWD_SEL_WB;
    if (wb_reg_wr && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs2_addr)) fwd_b_sel = FWD_SEL_WB;
`ifdef RV_EX_FORWARDING_EN
    if (mem_reg_wr && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs1_addr)) fwd_a_sel = FWD_SEL_MEM;
    if (mem_reg_wr && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs2_addr)) fwd_b_sel = FWD_SEL_MEM;
`endif
  end

endmodule

// File: rtl/rv_id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Define RV_EX_FORWARDING_EN to enable the MEM-stage bypass.
import rv_id_ex_stage_pkg::*;

module rv_id_ex_stage (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic            i_id_rs1_used,
  input  logic            i_id_rs2_used,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic            i_id_src_a_sel,
  input  logic            i_id_src_b_sel,
  input  logic [3:0]      i_id_alu_ctrl,
  input  logic [4:0]      i_id_rd_addr,
  input  logic            i_id_reg_wr,
  input  logic            i_id_mem_rd,
  input  logic            i_id_mem_wr,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic            i_mem_reg_wr,
  input  logic [XLEN-1:0] i_mem_alu_res,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic            i_wb_reg_wr,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  output logic [XLEN-1:0] o_ex_store_data,
  output logic [4:0]      o_ex_rd_addr,
  output logic            o_ex_reg_wr,
  output logic            o_ex_mem_rd,
  output logic            o_ex_mem_wr
);

  id_ex_t   ex_q;
  id_ex_t   id_bundle;
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  assign id_bundle = '{
    valid:     1'b1,
    pc:        i_id_pc,
    rs1_addr:  i_id_rs1_addr,
    rs2_addr:  i_id_rs2_addr,
    rs1_data:  i_id_rs1_data,
    rs2_data:  i_id_rs2_data,
    imm:       i_id_imm,
    src_a_sel: i_id_src_a_sel,
    src_b_sel: i_id_src_b_sel,
    alu_ctrl:  i_id_alu_ctrl,
    rd_addr:   i_id_rd_addr,
    reg_wr:    i_id_reg_wr,
    mem_rd:    i_id_mem_rd,
    mem_wr:    i_id_mem_wr
  };

  rv_hazard_unit u_hazard (
    .id_valid    (i_id_valid),
    .flush       (i_flush),
    .id_rs1_addr (i_id_rs1_addr),
    .id_rs2_addr (i_id_rs2_addr),
    .id_rs1_used (i_id_rs1_used),
    .id_rs2_used (i_id_rs2_used),
    .ex_valid    (ex_q.valid),
    .ex_mem_rd   (ex_q.mem_rd),
`ifndef RV_EX_FORWARDING_EN
    .ex_reg_wr   (ex_q.reg_wr),
`endif
    .ex_rd_addr  (ex_q.rd_addr),
    .ex_rs1_addr (ex_q.rs1_addr),
    .ex_rs2_addr (ex_q.rs2_addr),
    .mem_rd_addr (i_mem_rd_addr),
    .mem_reg_wr  (i_mem_reg_wr),
    .wb_rd_addr  (i_wb_rd_addr),
    .wb_reg_wr   (i_wb_reg_wr),
    .stall       (o_stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  // Bubbles load all-zero so valid and every side-effect bit are cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q <= '0;
    end else if (i_flush || o_stall || !i_id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_bundle;
    end
  end

  always_comb begin
    case (fwd_a_sel)
      FWD_SEL_MEM: fwd_rs1 = i_mem_alu_res;
      FWD_SEL_WB:  fwd_rs1 = i_wb_data;
      default:     fwd_rs1 = ex_q.rs1_data;
    endcase
    case (fwd_b_sel)
      FWD_SEL_MEM: fwd_rs2 = i_mem_alu_res;
      FWD_SEL_WB:  fwd_rs2 = i_wb_data;
      default:     fwd_rs2 = ex_q.rs2_data;
    endcase
  end

  assign o_alu_a         = (ex_q.src_a_sel == SRC_A_SEL_PC)  ? ex_q.pc  : fwd_rs1;
  assign o_alu_b         = (ex_q.src_b_sel == SRC_B_SEL_IMM) ? ex_q.imm : fwd_rs2;
  assign o_ex_store_data = fwd_rs2;
  assign o_ex_valid      = ex_q.valid;
  assign o_ex_pc         = ex_q.pc;
  assign o_alu_ctrl      = ex_q.alu_ctrl;
  assign o_ex_rd_addr    = ex_q.rd_addr;
  assign o_ex_reg_wr     = ex_q.reg_wr;
  assign o_ex_mem_rd     = ex_q.mem_rd;
  assign o_ex_mem_wr     = ex_q.mem_wr;

endmodule

// File: tb/tb_rv_id_ex_stage.sv
// Self-checking bench for rv_id_ex_stage: directed pipeline scenarios followed
// by random traffic, compared against an instruction-level model of EX.
import rv_id_ex_stage_pkg::*;

module tb_rv_id_ex_stage;

`ifdef RV_EX_FORWARDING_EN
  localparam bit MEM_BYPASS = 1'b1;
`else
  localparam bit MEM_BYPASS = 1'b0;
`endif

  // Clock and reset
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic            i_id_valid;
  logic [XLEN-1:0] i_id_pc;
  logic [4:0]      i_id_rs1_addr, i_id_rs2_addr;
  logic            i_id_rs1_used, i_id_rs2_used;
  logic [XLEN-1:0] i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic            i_id_src_a_sel, i_id_src_b_sel;
  logic [3:0]      i_id_alu_ctrl;
  logic [4:0]      i_id_rd_addr;
  logic            i_id_reg_wr, i_id_mem_rd, i_id_mem_wr;
  logic [4:0]      i_mem_rd_addr;
  logic            i_mem_reg_wr;
  logic [XLEN-1:0] i_mem_alu_res;
  logic [4:0]      i_wb_rd_addr;
  logic            i_wb_reg_wr;
  logic [XLEN-1:0] i_wb_data;
  logic            i_flush;
  logic            o_stall, o_ex_valid;
  logic [XLEN-1:0] o_ex_pc, o_alu_a, o_alu_b, o_ex_store_data;
  logic [3:0]      o_alu_ctrl;
  logic [4:0]      o_ex_rd_addr;
  logic            o_ex_reg_wr, o_ex_mem_rd, o_ex_mem_wr;

  rv_id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data), .i_id_imm(i_id_imm),
    .i_id_src_a_sel(i_id_src_a_sel), .i_id_src_b_sel(i_id_src_b_sel),
    .i_id_alu_ctrl(i_id_alu_ctrl), .i_id_rd_addr(i_id_rd_addr), .i_id_reg_wr(i_id_reg_wr),
    .i_id_mem_rd(i_id_mem_rd), .i_id_mem_wr(i_id_mem_wr),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_reg_wr(i_mem_reg_wr), .i_mem_alu_res(i_mem_alu_res),
    .i_wb_rd_addr(i_wb_rd_addr), .i_wb_reg_wr(i_wb_reg_wr), .i_wb_data(i_wb_data),
    .i_flush(i_flush), .o_stall(o_stall), .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
    .o_ex_store_data(o_ex_store_data), .o_ex_rd_addr(o_ex_rd_addr),
    .o_ex_reg_wr(o_ex_reg_wr), .o_ex_mem_rd(o_ex_mem_rd), .o_ex_mem_wr(o_ex_mem_wr)
  );

  // Model of the instruction currently sitting in EX
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] pc, d1, d2, imm;
    logic [4:0]      rs1, rs2, rd;
    logic            asel, bsel, reg_wr, mem_rd, mem_wr;
    logic [3:0]      ctrl;
  } ex_model_t;

  ex_model_t m;
  int checks = 0;
  int errors = 0;
  logic exp_stall;

  // Scoreboard
  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads(input logic [4:0] rd);
    return i_id_valid && (rd != 0) &&
           ((i_id_rs1_used && i_id_rs1_addr == rd) || (i_id_rs2_used && i_id_rs2_addr == rd));
  endfunction

  function automatic logic model_stall();
    bit s;
    if (i_flush) return 1'b0;
    s = m.valid && m.mem_rd && id_reads(m.rd);
    if (!MEM_BYPASS)
      s = s || (m.valid && m.reg_wr && id_reads(m.rd)) || (i_mem_reg_wr && id_reads(i_mem_rd_addr));
    return s;
  endfunction

  function automatic logic [XLEN-1:0] model_operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 0) return rf;
    if (MEM_BYPASS && i_mem_reg_wr && i_mem_rd_addr == rs) return i_mem_alu_res;
    if (i_wb_reg_wr && i_wb_rd_addr == rs) return i_wb_data;
    return rf;
  endfunction

  // One clock: check outputs for the applied inputs, then advance the model.
  task automatic step(input bit chk);
    logic [XLEN-1:0] f1, f2;
    #1;
    exp_stall = model_stall();
    if (chk) begin
      f1 = model_operand(m.rs1, m.d1);
      f2 = model_operand(m.rs2, m.d2);
      check("stall",      XLEN'(o_stall),      XLEN'(exp_stall));
      check("ex_valid",   XLEN'(o_ex_valid),   XLEN'(m.valid));
      check("ex_pc",      o_ex_pc,             m.pc);
      check("alu_a",      o_alu_a,             m.asel ? m.pc : f1);
      check("alu_b",      o_alu_b,             m.bsel ? m.imm : f2);
      check("store_data", o_ex_store_data,     f2);
      check("alu_ctrl",   XLEN'(o_alu_ctrl),   XLEN'(m.ctrl));
      check("rd_addr",    XLEN'(o_ex_rd_addr), XLEN'(m.rd));
      check("reg_wr",     XLEN'(o_ex_reg_wr),  XLEN'(m.reg_wr));
      check("mem_rd",     XLEN'(o_ex_mem_rd),  XLEN'(m.mem_rd));
      check("mem_wr",     XLEN'(o_ex_mem_wr),  XLEN'(m.mem_wr));
    end
    @(posedge i_clk);
    if (i_rst || i_flush || exp_stall || !i_id_valid) begin
      m = '{default: '0};
    end else begin
      m.valid = 1'b1;          m.pc = i_id_pc;
      m.d1 = i_id_rs1_data;    m.d2 = i_id_rs2_data;  m.imm = i_id_imm;
      m.rs1 = i_id_rs1_addr;   m.rs2 = i_id_rs2_addr; m.rd = i_id_rd_addr;
      m.asel = i_id_src_a_sel; m.bsel = i_id_src_b_sel;
      m.reg_wr = i_id_reg_wr;  m.mem_rd = i_id_mem_rd; m.mem_wr = i_id_mem_wr;
      m.ctrl = i_id_alu_ctrl;
    end
    @(negedge i_clk);
  endtask

  // Driver tasks
  task automatic id_instr(input logic [XLEN-1:0] pc,
                          input logic [4:0] rs1, input logic u1, input logic [XLEN-1:0] d1,
                          input logic [4:0] rs2, input logic u2, input logic [XLEN-1:0] d2,
                          input logic [XLEN-1:0] imm, input logic asel, input logic bsel,
                          input logic [3:0] ctrl, input logic [4:0] rd,
                          input logic rwr, input logic mrd, input logic mwr);
    i_id_valid = 1'b1; i_id_pc = pc;
    i_id_rs1_addr = rs1; i_id_rs1_used = u1; i_id_rs1_data = d1;
    i_id_rs2_addr = rs2; i_id_rs2_used = u2; i_id_rs2_data = d2;
    i_id_imm = imm; i_id_src_a_sel = asel; i_id_src_b_sel = bsel;
    i_id_alu_ctrl = ctrl; i_id_rd_addr = rd;
    i_id_reg_wr = rwr; i_id_mem_rd = mrd; i_id_mem_wr = mwr;
  endtask

  task automatic id_nop();
    id_instr('0, 5'd0, 1'b0, '0, 5'd0, 1'b0, '0, '0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    i_id_valid = 1'b0;
  endtask

  task automatic mem_set(input logic [4:0] rd, input logic wr, input logic [XLEN-1:0] res);
    i_mem_rd_addr = rd; i_mem_reg_wr = wr; i_mem_alu_res = res;
  endtask

  task automatic wb_set(input logic [4:0] rd, input logic wr, input logic [XLEN-1:0] data);
    i_wb_rd_addr = rd; i_wb_reg_wr = wr; i_wb_data = data;
  endtask

  initial begin
    m = '{default: '0};
    i_rst = 1'b1; i_flush = 1'b0;
    mem_set(5'd0, 1'b0, '0); wb_set(5'd0, 1'b0, '0);
    // Reset held two cycles with a valid ID instruction present
    id_instr(32'h100, 5'd1, 1'b1, 32'h1, 5'd2, 1'b1, 32'h2, '0, 1'b0, 1'b0, ALU_ADD, 5'd5, 1'b1, 1'b0, 1'b0);
    step(1'b0);
    step(1'b1);
    i_rst = 1'b0;
    step(1'b1);
    id_nop();
    step(1'b1);

    // MEM forward: sub x6,x5,x3 with x5 produced by the instruction in MEM
    id_instr(32'h104, 5'd5, 1'b1, 32'h0, 5'd3, 1'b1, 32'h7, '0, 1'b0, 1'b0, ALU_SUB, 5'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    id_nop(); mem_set(5'd5, 1'b1, 32'h0000_0010);
    step(1'b1);

    // MEM-over-WB priority on rs2, then WB alone
    mem_set(5'd0, 1'b0, '0);
    id_instr(32'h108, 5'd1, 1'b1, 32'h11, 5'd5, 1'b1, 32'h55, '0, 1'b0, 1'b0, ALU_ADD, 5'd9, 1'b1, 1'b0, 1'b1);
    step(1'b1);
    id_nop(); mem_set(5'd5, 1'b1, 32'hAA); wb_set(5'd5, 1'b1, 32'hBB);
    step(1'b1);
    mem_set(5'd5, 1'b0, 32'hAA);
    step(1'b1);

    // x0 is never forwarded
    mem_set(5'd0, 1'b0, '0); wb_set(5'd0, 1'b0, '0);
    id_instr(32'h10C, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, '0, 1'b0, 1'b0, ALU_ADD, 5'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    id_nop(); mem_set(5'd0, 1'b1, 32'hFFFF_FFFF); wb_set(5'd0, 1'b1, 32'hFFFF_FFFF);
    step(1'b1);

    // Load-use: lw x7 then add x8,x7,x7
    mem_set(5'd0, 1'b0, '0); wb_set(5'd0, 1'b0, '0);
    id_instr(32'h110, 5'd2, 1'b1, 32'h1000, 5'd0, 1'b0, '0, 32'h4, 1'b0, 1'b1, ALU_ADD, 5'd7, 1'b1, 1'b1, 1'b0);
    step(1'b1);
    id_instr(32'h114, 5'd7, 1'b1, 32'h0, 5'd7, 1'b1, 32'h0, '0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b1, 1'b0, 1'b0);
    step(1'b1);
    mem_set(5'd7, 1'b1, 32'h1234);
    step(1'b1);
    id_nop();
    step(1'b1);
    step(1'b1);

    // Flush during a load-use stall
    mem_set(5'd0, 1'b0, '0);
    id_instr(32'h118, 5'd2, 1'b1, 32'h1000, 5'd0, 1'b0, '0, 32'h8, 1'b0, 1'b1, ALU_ADD, 5'd7, 1'b1, 1'b1, 1'b0);
    step(1'b1);
    id_instr(32'h11C, 5'd7, 1'b1, 32'h0, 5'd7, 1'b1, 32'h0, '0, 1'b0, 1'b0, ALU_ADD, 5'd8, 1'b1, 1'b0, 1'b0);
    i_flush = 1'b1;
    step(1'b1);
    i_flush = 1'b0; id_nop();
    step(1'b1);

    // Reset asserted mid-stall
    id_instr(32'h120, 5'd2, 1'b1, 32'h1000, 5'd0, 1'b0, '0, 32'hC, 1'b0, 1'b1, ALU_ADD, 5'd7, 1'b1, 1'b1, 1'b0);
    step(1'b1);
    id_instr(32'h124, 5'd7, 1'b1, 32'h0, 5'd3, 1'b1, 32'h0, '0, 1'b0, 1'b0, ALU_SUB, 5'd8, 1'b1, 1'b0, 1'b0);
    i_rst = 1'b1;
    step(1'b1);
    i_rst = 1'b0;
    step(1'b1);

    // Random traffic; ID is held while the stage stalls
    for (int i = 0; i < 400; i++) begin
      if (!exp_stall || i_rst) begin
        id_instr($urandom, 5'($urandom_range(0, 3)), 1'($urandom), $urandom,
                 5'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                 1'($urandom), 1'($urandom), 4'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom));
        i_id_valid = ($urandom_range(0, 7) != 0);
      end
      mem_set(5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      wb_set(5'($urandom_range(0, 3)), 1'($urandom), $urandom);
      i_flush = ($urandom_range(0, 7) == 0);
      i_rst   = ($urandom_range(0, 63) == 0);
      step(1'b1);
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_id_ex_stage.md
Name: rv_id_ex_stage

Overview:
- ID/EX pipeline register plus the operand-forwarding and load-use hazard logic that directly feeds the ALU in the EX stage.
- Captures decoded operands and control from ID, then drives the final ALU A/B operands and the 4-bit ALU control.
- Bypasses results from the MEM and WB stages.
- Stalls the front end and inserts a bubble when a load result is not yet available.

Parameters:
- XLEN, `XLEN (32): datapath width; taken from the shared config include.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_pc  in  XLEN  PC of the ID instruction
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  source register indices
- i_id_rs1_used, i_id_rs2_used  in  1 each  instruction actually reads rs1/rs2
- i_id_rs1_data, i_id_rs2_data  in  XLEN each  register-file read data
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_src_a_sel  in  1  0=rs1, 1=pc
- i_id_src_b_sel  in  1  0=rs2, 1=imm
- i_id_alu_ctrl  in  4  ALU operation code
- i_id_rd_addr  in  5  destination register
- i_id_reg_wr  in  1  instruction writes rd
- i_id_mem_rd  in  1  instruction is a load
- i_id_mem_wr  in  1  instruction is a store
- i_mem_rd_addr, i_mem_reg_wr, i_mem_alu_res  in  5/1/XLEN  MEM-stage instruction: rd, write enable, ALU result
- i_wb_rd_addr, i_wb_reg_wr, i_wb_data  in  5/1/XLEN  WB-stage instruction: rd, write enable, final write data
- i_flush  in  1  squash the ID instruction (taken branch/jump resolved in EX)
- o_stall  out  1  hold PC and IF/ID this cycle
- o_ex_valid  out  1  EX holds a real instruction
- o_ex_pc  out  XLEN  registered PC
- o_alu_a, o_alu_b  out  XLEN each  forwarded ALU operands
- o_alu_ctrl  out  4  registered ALU op
- o_ex_store_data  out  XLEN  forwarded rs2 value, used for stores
- o_ex_rd_addr, o_ex_reg_wr, o_ex_mem_rd, o_ex_mem_wr  out  5/1/1/1  registered destination and memory control

Behaviour:
- Clock and reset:
  - Single clock domain, i_clk.
  - i_rst is synchronous and active-high.
  - On reset, every ID/EX register is cleared to 0: o_ex_valid=0, o_ex_reg_wr=0, o_ex_mem_rd=0, o_ex_mem_wr=0, o_alu_ctrl=0, pc/rd/data=0.
  - Reset asserted mid-stall clears state. o_stall follows the combinational hazard equation on the cleared state, which yields 0.
- Register update, one cycle of latency, ID data visible in EX the next cycle:
  - Bubble case: if i_flush or o_stall or !i_id_valid, load a bubble. That means valid=0 and reg_wr, mem_rd, mem_wr all 0; data fields hold don't-care, and the RTL loads 0.
  - Otherwise, capture all ID fields with valid=1.
- Load-use hazard (combinational):
  - ex_ld = o_ex_valid & o_ex_mem_rd & o_ex_rd_addr!=0.
  - o_stall = i_id_valid & !i_flush & ex_ld & ((i_id_rs1_used & rs1==ex_rd) | (i_id_rs2_used & rs2==ex_rd)).
  - A stall lasts exactly 1 cycle, after which the load sits in MEM and is forwarded.
  - While o_stall is high, IF/ID holds externally. This block re-presents the same ID inputs the next cycle.
- Flush: i_flush wins over stall. o_stall is forced low, and a bubble is loaded.
- Forwarding (combinational on registered rs indices, evaluated separately per source):
  - Priority: MEM (i_mem_reg_wr & rd==rsX & rd!=0) → i_mem_alu_res; else WB (same test) → i_wb_data; else the registered register-file data.
  - x0 is never forwarded.
  - When MEM and WB both match, MEM wins because it is younger.
- Operand muxes:
  - o_alu_a = src_a_sel ? pc : fwd_rs1.
  - o_alu_b = src_b_sel ? imm : fwd_rs2.
  - o_ex_store_data = fwd_rs2, always.
- Outputs are valid-agnostic. Consumers qualify with o_ex_valid.

Optional Feature:
- Macro: RV_EX_FORWARDING_EN.
- Defined: the MEM and WB bypass described above is enabled; the only stall is load-use.
- Undefined:
  - The MEM bypass is removed.
  - o_stall additionally asserts when any used ID source equals a valid EX rd with reg_wr=1, or a MEM rd with reg_wr=1, for rd!=0.
  - The WB bypass remains in both builds because the register file is not write-first.

Decomposition:
- The shared config include holds:
  - XLEN
  - SRC_A_SEL_RS1/PC and SRC_B_SEL_RS2/IMM
  - forward-select encodings FWD_SEL_RF=2'd0, FWD_SEL_MEM=2'd1, FWD_SEL_WB=2'd2
- One natural sub-module, rv_hazard_unit. It is combinational, produces o_stall and per-source forward selects, and is instantiated once.

Test Plan:
- Reset: hold i_rst for 2 cycles with i_id_valid=1 → o_ex_valid=0, o_stall=0, o_ex_reg_wr=0 throughout and on the first edge after release.
- MEM forward, add x5,x1,x2 followed by sub x6,x5,x3:
  - Setup: MEM rd=5, alu_res=0x0000_0010; rf x5=0.
  - Required: o_alu_a=0x10, o_alu_ctrl=SUB, no stall.
- MEM-over-WB priority:
  - Setup: MEM rd=5 res=0xAA, WB rd=5 data=0xBB, rs2=5.
  - Required: o_alu_b=0xAA, and o_ex_store_data=0xAA.
- x0 guard: MEM rd=0, reg_wr=1, res=0xFFFF_FFFF, rs1=0, rf data=0 → o_alu_a=0.
- Load-use, lw x7 then add x8,x7,x7:
  - Required: o_stall=1 for exactly 1 cycle, then a bubble in EX (o_ex_valid=0).
  - Next cycle: the add enters with o_alu_a=o_alu_b=i_mem_alu_res.
- Flush during stall: same load-use case with i_flush=1 → o_stall=0, next o_ex_valid=0, o_ex_reg_wr=0.
